// File: rtl/obstacle_feeder_pkg.sv
// -----------------------------------------------------------------------------
// obstacle_pkg
// Shared types and helpers for the procedural obstacle feeder:
//   - default height-code width
//   - Galois LFSR toggle mask and single-step function
//   - gap/pipe FSM state encoding
//   - column record {height, first}
// -----------------------------------------------------------------------------
package obstacle_pkg;

    localparam int          HEIGHT_W_DEF = 2;
    localparam logic [15:0] LFSR_MASK    = 16'hB400;

    typedef enum logic {
        S_GAP  = 1'b0,
        S_PIPE = 1'b1
    } fsm_state_e;

    typedef struct packed {
        logic [HEIGHT_W_DEF-1:0] height;
        logic                    first;
    } column_t;

    // One step of a 16-bit right-shifting Galois LFSR: the mask is applied
    // whenever the bit shifted out of position 0 was set.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        lfsr_step = {1'b0, s[15:1]} ^ (s[0] ? LFSR_MASK : 16'h0000);
    endfunction

endpackage

// File: rtl/obstacle_feeder_if.sv
// -----------------------------------------------------------------------------
// obstacle_feeder_if
// Column stream between the obstacle feeder (master) and the game datapath
// (slave).
//   col_valid  : head column available
//   col_ready  : consumer takes the head column this cycle
//   col_height : head column height, 0 = no pipe
//   col_first  : head column is the first column of a pipe
// -----------------------------------------------------------------------------
interface obstacle_feeder_if #(
    parameter int HEIGHT_W = 2
);
    logic                col_valid;
    logic                col_ready;
    logic [HEIGHT_W-1:0] col_height;
    logic                col_first;

    modport master (output col_valid, output col_height, output col_first,
                    input  col_ready);
    modport slave  (input  col_valid, input  col_height, input  col_first,
                    output col_ready);
endinterface

// File: rtl/obstacle_feeder_col_fifo.sv
// -----------------------------------------------------------------------------
// col_fifo
// Small synchronous FIFO with a registered head.
//   clk, resetn : clock, asynchronous active-low reset
//   clr         : synchronous flush (dominates push/pop)
//   push/wr_data: write one entry (ignored when full unless popping)
//   pop         : drop the head entry (ignored when empty)
//   head        : registered head entry, 0 when empty
//   head_valid  : registered "not empty"
//   full        : occupancy equals DEPTH
// -----------------------------------------------------------------------------
module col_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             head_valid,
    output logic             full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             valid_q, valid_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
        // Head is taken from the post-update storage so a push into an empty
        // FIFO (or a pop that exposes the next entry) lands in the head
        // register at the same edge.
        valid_d = (count_d != '0);
        head_d  = valid_d ? mem_d[rd_ptr_d] : '0;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
        end
    end

    assign head       = head_q;
    assign head_valid = valid_q;

endmodule

// File: rtl/obstacle_feeder.sv
// -----------------------------------------------------------------------------
// obstacle_feeder
// Procedural obstacle source: a gap/pipe FSM, stepped by a 16-bit Galois LFSR,
// fills a lookahead FIFO that the game datapath drains one column per scroll
// tick.
//   clk        : system clock
//   resetn     : asynchronous active-low reset
//   start      : synchronous restart (level), same effect as reset
//   col        : column stream (master side of obstacle_feeder_if)
//   pipe_count : pipes popped (first columns only), saturates at 255
// Optional build macro DIFFICULTY_RAMP_EN: the minimum gap shrinks by one per
// 8 pipes popped, floored at 2.
// -----------------------------------------------------------------------------
module obstacle_feeder
    import obstacle_pkg::*;
#(
    parameter logic [15:0] SEED     = 16'hACE1,
    parameter int          HEIGHT_W = HEIGHT_W_DEF,
    parameter int          MIN_GAP  = 4,
    parameter int          GAP_LOG2 = 3,
    parameter int          PIPE_W   = 2,
    parameter int          DEPTH    = 4
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      start,
    obstacle_feeder_if.master         col,
    output logic [7:0]                pipe_count
);
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam int          RUN_W    = 8;
    localparam int          COL_W    = HEIGHT_W + 1;

    fsm_state_e          state_q, state_d;
    logic [RUN_W-1:0]    run_q, run_d;
    logic [15:0]         lfsr_q, lfsr_d, lfsr_nxt;
    logic [HEIGHT_W-1:0] h_q, h_d;
    logic [7:0]          pipe_count_q, pipe_count_d;
    logic [RUN_W-1:0]    min_gap;
    logic [COL_W-1:0]    push_col, head_col;
    logic                full, head_valid, push, pop;

    // start freezes the stream for the cycle: nothing is popped or pushed.
    assign pop  = head_valid && col.col_ready && !start;
    assign push = (!full || pop) && !start;

`ifdef DIFFICULTY_RAMP_EN
    always_comb begin
        if (RUN_W'(MIN_GAP) >= RUN_W'(pipe_count_q[7:3]) + RUN_W'(2)) begin
            min_gap = RUN_W'(MIN_GAP) - RUN_W'(pipe_count_q[7:3]);
        end else begin
            min_gap = RUN_W'(2);
        end
    end
`else
    assign min_gap = RUN_W'(MIN_GAP);
`endif

    always_comb begin
        lfsr_nxt     = lfsr_step(lfsr_q);
        state_d      = state_q;
        run_d        = run_q;
        lfsr_d       = lfsr_q;
        h_d          = h_q;
        pipe_count_d = pipe_count_q;

        if (state_q == S_GAP) begin
            push_col = '0;
        end else begin
            push_col = {h_q, (run_q == RUN_W'(PIPE_W))};
        end

        // The FSM only moves on a push, and the LFSR only on a draw, so the
        // column sequence depends on SEED alone, not on consumer timing.
        if (push) begin
            run_d = run_q - 1'b1;
            if (run_q == RUN_W'(1)) begin
                lfsr_d = lfsr_nxt;
                if (state_q == S_GAP) begin
                    h_d     = (lfsr_nxt[15 -: HEIGHT_W] == '0) ? HEIGHT_W'(1)
                                                               : lfsr_nxt[15 -: HEIGHT_W];
                    run_d   = RUN_W'(PIPE_W);
                    state_d = S_PIPE;
                end else begin
                    run_d   = min_gap + RUN_W'(lfsr_nxt[GAP_LOG2-1:0]);
                    state_d = S_GAP;
                end
            end
        end

        if (pop && head_col[0] && (pipe_count_q != 8'hFF)) begin
            pipe_count_d = pipe_count_q + 8'd1;
        end

        if (start) begin
            state_d      = S_GAP;
            run_d        = RUN_W'(MIN_GAP);
            lfsr_d       = SEED_EFF;
            h_d          = '0;
            pipe_count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_GAP;
            run_q        <= RUN_W'(MIN_GAP);
            lfsr_q       <= SEED_EFF;
            h_q          <= '0;
            pipe_count_q <= '0;
        end else begin
            state_q      <= state_d;
            run_q        <= run_d;
            lfsr_q       <= lfsr_d;
            h_q          <= h_d;
            pipe_count_q <= pipe_count_d;
        end
    end

    col_fifo #(
        .WIDTH (COL_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .clr        (start),
        .push       (push),
        .wr_data    (push_col),
        .pop        (pop),
        .head       (head_col),
        .head_valid (head_valid),
        .full       (full)
    );

    assign col.col_valid  = head_valid;
    assign col.col_height = head_col[COL_W-1:1];
    assign col.col_first  = head_col[0];
    assign pipe_count     = pipe_count_q;

endmodule

// File: tb/tb_obstacle_feeder.sv
module tb_obstacle_feeder;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic [7:0] pipe_count;

    int checks   = 0;
    int failures = 0;

    logic [1:0] exp_h [1:50];
    logic       exp_f [1:50];
    int         fill_idx = 1;

    obstacle_feeder_if #(.HEIGHT_W(2)) col_if ();

    obstacle_feeder dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .col        (col_if),
        .pipe_count (pipe_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add_gap(input int n);
        for (int k = 0; k < n; k++) begin
            exp_h[fill_idx] = 2'd0;
            exp_f[fill_idx] = 1'b0;
            fill_idx++;
        end
    endtask

    task automatic add_pipe(input logic [1:0] h);
        exp_h[fill_idx] = h; exp_f[fill_idx] = 1'b1; fill_idx++;
        exp_h[fill_idx] = h; exp_f[fill_idx] = 1'b0; fill_idx++;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (col_if.col_valid !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, {31'd0, col_if.col_valid}, 32'd1);
    endtask

    // Check the head against the table, then let exactly one edge pop it.
    task automatic pop_expect(input int i);
        wait_valid($sformatf("pop%0d", i));
        check($sformatf("pop%0d_height", i), {30'd0, col_if.col_height}, {30'd0, exp_h[i]});
        check($sformatf("pop%0d_first", i), {31'd0, col_if.col_first}, {31'd0, exp_f[i]});
        col_if.col_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int zeros, pipes_seen, gmin, gmax, late_gmax, bad, pipe_len, pops, cyc;
        logic [1:0] cur_h;

        // Hand-derived stream for SEED 0xACE1:
        // draws E270(h3) 7138(gap4) 389C(h1) 1C4E(gap10) B313.. see gaps below
        add_gap(4);  add_pipe(2'd3);
        add_gap(4);  add_pipe(2'd1);
        add_gap(10); add_pipe(2'd1);
        add_gap(7);  add_pipe(2'd3);
        add_gap(8);  add_pipe(2'd1);
        add_gap(5);  add_pipe(2'd2);

        resetn = 1'b0;
        start  = 1'b0;
        col_if.col_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", {31'd0, col_if.col_valid}, 32'd0);
        check("rst_height", {30'd0, col_if.col_height}, 32'd0);
        check("rst_first", {31'd0, col_if.col_first}, 32'd0);
        check("rst_pipe_count", {24'd0, pipe_count}, 32'd0);

        // Release with col_ready already high while the FIFO is empty.
        resetn = 1'b1;
        col_if.col_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("edge1_valid", {31'd0, col_if.col_valid}, 32'd1);
        check("empty_ready_rdptr", {30'd0, dut.u_fifo.rd_ptr_q}, 32'd0);
        check("empty_ready_pc", {24'd0, pipe_count}, 32'd0);
        col_if.col_ready = 1'b0;
        repeat (9) @(negedge clk);
        check("fill_count", {29'd0, dut.u_fifo.count_q}, 32'd4);

        // Continuous pops, with a one-cycle ready pulse on a full FIFO at pop 41.
        for (int i = 1; i <= 50; i++) begin
            if (i == 41) begin
                col_if.col_ready = 1'b0;
                repeat (5) @(negedge clk);
                check("full_count", {29'd0, dut.u_fifo.count_q}, 32'd4);
            end
            pop_expect(i);
            if (i == 41) begin
                col_if.col_ready = 1'b0;
                check("pulse_count", {29'd0, dut.u_fifo.count_q}, 32'd4);
                repeat (3) @(negedge clk);
            end
            if (i == 4) check("pc_after4", {24'd0, pipe_count}, 32'd0);
            if (i == 5) check("pc_after5", {24'd0, pipe_count}, 32'd1);
        end
        check("pc_after50", {24'd0, pipe_count}, 32'd6);

        // Level start held two cycles while ready is high.
        start = 1'b1;
        @(posedge clk); @(negedge clk);
        check("start_hold_valid", {31'd0, col_if.col_valid}, 32'd0);
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        check("start_valid", {31'd0, col_if.col_valid}, 32'd0);
        check("start_pc", {24'd0, pipe_count}, 32'd0);
        check("start_lfsr", {16'd0, dut.lfsr_q}, 32'h0000ACE1);
        check("start_count", {29'd0, dut.u_fifo.count_q}, 32'd0);
        for (int i = 1; i <= 5; i++) pop_expect(i);
        check("replay_pc5", {24'd0, pipe_count}, 32'd1);

        // Restart in the middle of a pipe (head is its second column).
        start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        check("midpipe_pc", {24'd0, pipe_count}, 32'd0);
        check("midpipe_valid", {31'd0, col_if.col_valid}, 32'd0);
        check("midpipe_lfsr", {16'd0, dut.lfsr_q}, 32'h0000ACE1);
        for (int i = 1; i <= 6; i++) pop_expect(i);
        check("midpipe_replay_pc", {24'd0, pipe_count}, 32'd1);

        // Long run from a fresh start: structural checks and saturation.
        start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        col_if.col_ready = 1'b1;
        zeros = 0; pipes_seen = 0; gmin = 99; gmax = 0; late_gmax = 0;
        bad = 0; pipe_len = 0; pops = 0; cyc = 0; cur_h = 2'd0;
        while (pops < 4000 && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            if (col_if.col_valid === 1'b1) begin
                pops++;
                if (col_if.col_height == 2'd0) begin
                    if (col_if.col_first !== 1'b0) bad++;
                    if (pipe_len != 0 && pipe_len != 2) bad++;
                    pipe_len = 0;
                    zeros++;
                end else if (col_if.col_first === 1'b1) begin
                    if (pipe_len != 0) bad++;
                    if (pipes_seen > 0) begin
                        if (zeros < gmin) gmin = zeros;
                        if (zeros > gmax) gmax = zeros;
                        if (pipes_seen >= 20 && zeros > late_gmax) late_gmax = zeros;
                    end
                    pipes_seen++;
                    zeros = 0;
                    pipe_len = 1;
                    cur_h = col_if.col_height;
                end else begin
                    if (pipe_len != 1 || col_if.col_height != cur_h) bad++;
                    pipe_len++;
                end
            end
        end
        check("long_pops", pops, 32'd4000);
        check("long_pipe_shape", bad, 32'd0);
        check("long_pc_sat", {24'd0, pipe_count}, 32'd255);
        check("long_pipes_seen_ge255", {31'd0, pipes_seen >= 255}, 32'd1);
`ifdef DIFFICULTY_RAMP_EN
        check("ramp_gap_min_ge2", {31'd0, gmin >= 2}, 32'd1);
        check("ramp_gap_max_le11", {31'd0, gmax <= 11}, 32'd1);
        check("ramp_late_gap_le9", {31'd0, late_gmax <= 9}, 32'd1);
`else
        check("gap_min_ge4", {31'd0, gmin >= 4}, 32'd1);
        check("gap_max_le11", {31'd0, gmax <= 11}, 32'd1);
`endif
        col_if.col_ready = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
